// File: rtl/ring_router_gateway_mux.sv
// Output-side worm arbiter of a ring router with gateway.
// Merges ring, local and external flit streams onto the next ring hop.
module ring_router_gateway_mux #(
    parameter int RING_WEIGHT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] in_ring_data,
    input  logic        in_ring_last,
    input  logic        in_ring_valid,
    output logic        in_ring_ready,
    input  logic [15:0] in_local_data,
    input  logic        in_local_last,
    input  logic        in_local_valid,
    output logic        in_local_ready,
    input  logic [15:0] in_ext_data,
    input  logic        in_ext_last,
    input  logic        in_ext_valid,
    output logic        in_ext_ready,
    output logic [15:0] out_ring_data,
    output logic        out_ring_last,
    output logic        out_ring_valid,
    input  logic        out_ring_ready,
    output logic [2:0]  grant
);
    localparam int CW = $clog2(RING_WEIGHT + 1);
    localparam logic [CW-1:0] CREDIT_MAX = CW'(RING_WEIGHT);
    localparam logic [1:0] SEL_RING  = 2'd0;
    localparam logic [1:0] SEL_LOCAL = 2'd1;
    localparam logic [1:0] SEL_EXT   = 2'd2;

    typedef enum logic [1:0] {IDLE, HOLD, LOCKED} state_t;

    state_t        state, state_d;
    logic [1:0]    sel, sel_d, arb_sel, cur_sel, rr_first, rr_second;
    logic [CW-1:0] ring_credit, ring_credit_d;
    logic          rr_ptr, rr_ptr_d;
    logic          first_req, second_req, arb_any, active;
    logic          cur_valid, cur_last, xfer, first_xfer;

    assign rr_first   = rr_ptr ? SEL_EXT : SEL_LOCAL;
    assign rr_second  = rr_ptr ? SEL_LOCAL : SEL_EXT;
    assign first_req  = rr_ptr ? in_ext_valid : in_local_valid;
    assign second_req = rr_ptr ? in_local_valid : in_ext_valid;
    assign arb_any    = in_ring_valid | in_local_valid | in_ext_valid;

    // Ring drops to last place once its credit is spent
    always_comb begin
        arb_sel = SEL_RING;
        if (ring_credit != '0) begin
            if (in_ring_valid)   arb_sel = SEL_RING;
            else if (first_req)  arb_sel = rr_first;
            else if (second_req) arb_sel = rr_second;
        end else begin
            if (first_req)       arb_sel = rr_first;
            else if (second_req) arb_sel = rr_second;
        end
    end

    assign cur_sel = (state == IDLE) ? arb_sel : sel;
    assign active  = rst & ((state == IDLE) ? arb_any : 1'b1);

    always_comb begin
        cur_valid     = in_ring_valid;
        cur_last      = in_ring_last;
        out_ring_data = in_ring_data;
        case (cur_sel)
            SEL_LOCAL: begin
                cur_valid     = in_local_valid;
                cur_last      = in_local_last;
                out_ring_data = in_local_data;
            end
            SEL_EXT: begin
                cur_valid     = in_ext_valid;
                cur_last      = in_ext_last;
                out_ring_data = in_ext_data;
            end
            default: ;
        endcase
    end

    assign out_ring_valid = active & cur_valid;
    assign out_ring_last  = cur_last;
    assign grant          = active ? (3'b001 << cur_sel) : 3'b000;
    assign in_ring_ready  = grant[0] & out_ring_ready;
    assign in_local_ready = grant[1] & out_ring_ready;
    assign in_ext_ready   = grant[2] & out_ring_ready;
    assign xfer           = out_ring_valid & out_ring_ready;
    assign first_xfer     = xfer & (state != LOCKED);

    always_comb begin
        state_d       = state;
        sel_d         = sel;
        ring_credit_d = ring_credit;
        rr_ptr_d      = rr_ptr;
        case (state)
            IDLE: begin
                if (arb_any) begin
                    sel_d = arb_sel;
                    if (xfer) state_d = cur_last ? IDLE : LOCKED;
                    else      state_d = HOLD;
                end
            end
            HOLD: begin
                if (!cur_valid) state_d = IDLE;
                else if (xfer)  state_d = cur_last ? IDLE : LOCKED;
            end
            LOCKED: begin
                if (xfer && cur_last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Credit and pointer move once per worm, on its first flit
        if (first_xfer) begin
            if (cur_sel == SEL_RING) begin
                if (ring_credit != '0) ring_credit_d = ring_credit - 1'b1;
            end else begin
                ring_credit_d = CREDIT_MAX;
                rr_ptr_d      = (cur_sel == SEL_LOCAL);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            sel         <= SEL_RING;
            ring_credit <= CREDIT_MAX;
            rr_ptr      <= 1'b0;
        end else begin
            state       <= state_d;
            sel         <= sel_d;
            ring_credit <= ring_credit_d;
            rr_ptr      <= rr_ptr_d;
        end
    end
endmodule

// File: tb/tb_ring_router_gateway_mux.sv
// Bench for ring_router_gateway_mux: directed scenarios plus random
// traffic, all checked against a worm-level arbitration model.
module tb_ring_router_gateway_mux;
    localparam int RW = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] td [3];
    logic        tl [3];
    logic        tv [3];
    logic        ordy;
    logic        rrdy, lrdy, erdy;
    logic [15:0] odata;
    logic        olast, ovalid;
    logic [2:0]  grant;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    int m_owner, m_credit, m_sel;
    bit m_started, m_rr, m_xfer, m_first;
    logic [2:0] obs_grant;

    ring_router_gateway_mux #(.RING_WEIGHT(RW)) dut (
        .clk(clk), .rst(rst),
        .in_ring_data(td[0]), .in_ring_last(tl[0]),
        .in_ring_valid(tv[0]), .in_ring_ready(rrdy),
        .in_local_data(td[1]), .in_local_last(tl[1]),
        .in_local_valid(tv[1]), .in_local_ready(lrdy),
        .in_ext_data(td[2]), .in_ext_last(tl[2]),
        .in_ext_valid(tv[2]), .in_ext_ready(erdy),
        .out_ring_data(odata), .out_ring_last(olast),
        .out_ring_valid(ovalid), .out_ring_ready(ordy),
        .grant(grant)
    );

    always #5 clk = ~clk;

    task automatic check(string tag, logic [15:0] obs, logic [15:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int pick(logic [2:0] v);
        int f, s;
        f = m_rr ? 2 : 1;
        s = m_rr ? 1 : 2;
        if (m_credit > 0) begin
            if (v[0]) return 0;
            if (v[f]) return f;
            if (v[s]) return s;
        end else begin
            if (v[f]) return f;
            if (v[s]) return s;
            if (v[0]) return 0;
        end
        return -1;
    endfunction

    task automatic idle_inputs();
        for (int i = 0; i < 3; i++) begin
            tv[i] = 1'b0;
            tl[i] = 1'b1;
            td[i] = 16'h0;
        end
    endtask

    task automatic rst_step(string tag);
        rst = 1'b0;
        #1;
        check({tag, ".grant"}, 16'(grant), 16'h0);
        check({tag, ".valid"}, 16'(ovalid), 16'h0);
        check({tag, ".readies"}, 16'({erdy, lrdy, rrdy}), 16'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        m_owner = -1;
        m_started = 0;
        m_credit = RW;
        m_rr = 0;
    endtask

    // One cycle: settle, compare against the model, then advance model and clock
    task automatic step(string tag);
        logic [2:0] v, eg, er;
        int s;
        bit act, ev;
        #1;
        v = {tv[2], tv[1], tv[0]};
        s = (m_owner >= 0) ? m_owner : pick(v);
        act = (s >= 0);
        eg = act ? 3'(1 << s) : 3'b000;
        ev = act && v[s];
        er = ordy ? eg : 3'b000;
        obs_grant = grant;
        check({tag, ".grant"}, 16'(grant), 16'(eg));
        check({tag, ".valid"}, 16'(ovalid), 16'(ev));
        check({tag, ".readies"}, 16'({erdy, lrdy, rrdy}), 16'(er));
        if (ev) begin
            check({tag, ".data"}, odata, td[s]);
            check({tag, ".last"}, 16'(olast), 16'(tl[s]));
        end
        m_sel = s;
        m_xfer = ev && ordy;
        m_first = m_xfer && !m_started;
        if (m_xfer) begin
            if (!m_started) begin
                if (s == 0) begin
                    if (m_credit > 0) m_credit--;
                end else begin
                    m_credit = RW;
                    m_rr = (s == 1);
                end
            end
            if (tl[s]) begin
                m_owner = -1;
                m_started = 0;
            end else begin
                m_owner = s;
                m_started = 1;
            end
        end else if (act && m_owner < 0) begin
            m_owner = s;
            m_started = 0;
        end else if (m_owner >= 0 && !m_started && !v[s]) begin
            m_owner = -1;
        end
        @(posedge clk);
        #1;
    endtask

    int exp_seq [15] = '{1, 1, 1, 1, 2, 1, 1, 1, 1, 4, 1, 1, 1, 1, 2};
    int rem [3];
    int seq [3];
    int wi;

    initial begin
        idle_inputs();
        ordy = 1'b1;
        @(posedge clk);
        #1;
        rst_step("reset");

        // Single-flit local worm, granted the same cycle
        tv[1] = 1; td[1] = 16'h1234; tl[1] = 1;
        #1;
        check("loc.grant", 16'(grant), 16'h0002);
        check("loc.data", odata, 16'h1234);
        check("loc.ready", 16'(lrdy), 16'h1);
        step("loc");
        idle_inputs();
        step("loc.after");

        // Three saturating sources of 2-flit worms
        rst_step("rst2");
        for (int i = 0; i < 3; i++) begin
            tv[i] = 1; tl[i] = 0; td[i] = 16'(i * 16'h1000);
        end
        wi = 0;
        for (int c = 0; c < 30; c++) begin
            step("sat");
            if (m_first && wi < 15) begin
                check("sat.order", 16'(obs_grant), 16'(exp_seq[wi]));
                wi++;
            end
            if (m_xfer) begin
                tl[m_sel] = ~tl[m_sel];
                td[m_sel] = td[m_sel] + 16'h1;
            end
        end
        check("sat.worms", 16'(wi), 16'd15);
        idle_inputs();

        // Ring worm with a gap holds local off until its last flit
        rst_step("rst3");
        tv[0] = 1; tl[0] = 0; td[0] = 16'hA001;
        step("gap0");
        tv[1] = 1; tl[1] = 1; td[1] = 16'hB001; td[0] = 16'hA002;
        #1; check("gap1.lrdy", 16'(lrdy), 16'h0);
        step("gap1");
        tv[0] = 0;
        #1; check("gap2.lrdy", 16'(lrdy), 16'h0);
        step("gap2");
        tv[0] = 1; tl[0] = 1; td[0] = 16'hA003;
        #1; check("gap3.lrdy", 16'(lrdy), 16'h0);
        step("gap3");
        tv[0] = 0;
        #1; check("gap4.grant", 16'(grant), 16'h0002);
        step("gap4");
        idle_inputs();

        // Held ext flit is not pre-empted by ring while stalled
        rst_step("rst4");
        ordy = 0;
        tv[2] = 1; tl[2] = 1; td[2] = 16'hE0E0;
        step("hold0");
        tv[0] = 1; tl[0] = 1; td[0] = 16'hC0C0;
        #1; check("hold1.grant", 16'(grant), 16'h0004);
        step("hold1");
        step("hold2");
        ordy = 1;
        #1; check("hold3.data", odata, 16'hE0E0);
        step("hold3");
        tv[2] = 0;
        step("hold4");
        idle_inputs();

        // Ring alone exhausts credit but never stalls
        rst_step("rst5");
        tv[0] = 1; tl[0] = 1;
        for (int i = 0; i < 6; i++) begin
            td[0] = 16'(16'hD000 + i);
            #1; check("solo.rrdy", 16'(rrdy), 16'h1);
            step("solo");
        end
        tv[1] = 1; tl[1] = 1; td[1] = 16'h5A5A;
        #1; check("solo.loc", 16'(grant), 16'h0002);
        for (int i = 0; i < 10; i++) step("solo.mix");
        idle_inputs();

        // Reset mid-worm drops the local lock
        rst_step("rst6");
        tv[1] = 1; tl[1] = 0; td[1] = 16'h7777;
        step("lock0");
        rst_step("lock.rst");
        tv[1] = 0;
        tv[2] = 1; tl[2] = 1; td[2] = 16'h8888;
        #1; check("lock.ext", 16'(grant), 16'h0004);
        step("lock1");
        idle_inputs();

        // Random traffic
        rst_step("rst7");
        for (int i = 0; i < 3; i++) begin
            rem[i] = $urandom_range(1, 3);
            seq[i] = 0;
        end
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < 3; i++) begin
                tv[i] = ($urandom % 4) != 0;
                td[i] = {2'(i), 14'(seq[i])};
                tl[i] = (rem[i] == 1);
            end
            ordy = ($urandom % 4) != 0;
            step("rnd");
            if (m_xfer) begin
                seq[m_sel]++;
                rem[m_sel]--;
                if (rem[m_sel] == 0) rem[m_sel] = $urandom_range(1, 3);
            end
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
